// File: rtl/operand_scoreboard_if.sv
// operand_scoreboard_if: issue, writeback and operand-delivery signals of the scoreboard.
interface operand_scoreboard_if;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_a3;
    logic [4:0]  rs_a1;
    logic [4:0]  rs_a2;
    logic [31:0] grf_rd1;
    logic [31:0] grf_rd2;
    logic        wb_valid;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        stall;
    logic        op_valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sb_err;
    modport master (
        output issue_valid, issue_we, issue_a3, rs_a1, rs_a2, grf_rd1, grf_rd2,
        output wb_valid, wb_a3, wb_wd,
        input  stall, op_valid, op1, op2, sb_err
    );
    modport slave (
        input  issue_valid, issue_we, issue_a3, rs_a1, rs_a2, grf_rd1, grf_rd2,
        input  wb_valid, wb_a3, wb_wd,
        output stall, op_valid, op1, op2, sb_err
    );
endinterface

// File: rtl/operand_scoreboard.sv
// operand_scoreboard: per-register pending counts gating issue and latching operands.
// Define OPERAND_BYPASS_EN to let a reader take the writeback value in the writeback cycle.
module operand_scoreboard (
    input logic                 clk,
    input logic                 clr,
    operand_scoreboard_if.slave bus
);
`ifdef OPERAND_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    logic [1:0]  cnt [32];
    logic        hit1, hit2, rdy1, rdy2, full, fire, inc, dec;
    logic [31:0] v1, v2;
    // cnt[0] is only ever cleared, so register 0 is never pending
    always_comb begin
        hit1 = BYP && bus.wb_valid && bus.wb_a3 == bus.rs_a1 && cnt[bus.rs_a1] == 2'd1;
        hit2 = BYP && bus.wb_valid && bus.wb_a3 == bus.rs_a2 && cnt[bus.rs_a2] == 2'd1;
        rdy1 = cnt[bus.rs_a1] == 2'd0 || hit1;
        rdy2 = cnt[bus.rs_a2] == 2'd0 || hit2;
        // a same-cycle writeback to the destination frees the slot the issue needs
        full = bus.issue_we && bus.issue_a3 != 5'd0 && cnt[bus.issue_a3] == 2'd3 &&
               !(bus.wb_valid && bus.wb_a3 == bus.issue_a3);
        bus.stall = bus.issue_valid && (!rdy1 || !rdy2 || full);
        fire = bus.issue_valid && !bus.stall;
        inc = fire && bus.issue_we && bus.issue_a3 != 5'd0;
        dec = bus.wb_valid && bus.wb_a3 != 5'd0;
        v1 = hit1 ? bus.wb_wd : bus.rs_a1 == 5'd0 ? 32'h0 : bus.grf_rd1;
        v2 = hit2 ? bus.wb_wd : bus.rs_a2 == 5'd0 ? 32'h0 : bus.grf_rd2;
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
            bus.op_valid <= 1'b0;
            bus.op1 <= 32'h0;
            bus.op2 <= 32'h0;
            bus.sb_err <= 1'b0;
        end else begin
            bus.op_valid <= fire;
            if (fire) begin
                bus.op1 <= v1;
                bus.op2 <= v2;
            end
            if (dec && cnt[bus.wb_a3] == 2'd0) bus.sb_err <= 1'b1;
            for (int i = 1; i < 32; i++) begin
                if (inc && bus.issue_a3 == 5'(i) && !(dec && bus.wb_a3 == 5'(i)))
                    cnt[i] <= cnt[i] + 2'd1;
                else if (dec && bus.wb_a3 == 5'(i) && !(inc && bus.issue_a3 == 5'(i)) && cnt[i] != 2'd0)
                    cnt[i] <= cnt[i] - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_operand_scoreboard.sv
// tb_operand_scoreboard: directed scenarios plus random traffic against a pending-count model.
module tb_operand_scoreboard;
`ifdef OPERAND_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic clr;
    operand_scoreboard_if bus();
    operand_scoreboard dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cnt [32];
    bit err, eov;
    logic [31:0] eop1, eop2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        foreach (cnt[i]) cnt[i] = 0;
        err = 0; eov = 0; eop1 = 0; eop2 = 0;
    endtask

    task automatic idle();
        bus.issue_valid = 0; bus.issue_we = 0; bus.issue_a3 = 0; bus.rs_a1 = 0; bus.rs_a2 = 0;
        bus.grf_rd1 = 0; bus.grf_rd2 = 0; bus.wb_valid = 0; bus.wb_a3 = 0; bus.wb_wd = 0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit iv, input bit we, input logic [4:0] a3, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] d1, input logic [31:0] d2,
                        input bit wv, input logic [4:0] wa, input logic [31:0] wd);
        bit h1, h2, full, st, fire, inc, dec;
        bus.issue_valid = iv; bus.issue_we = we; bus.issue_a3 = a3; bus.rs_a1 = r1; bus.rs_a2 = r2;
        bus.grf_rd1 = d1; bus.grf_rd2 = d2; bus.wb_valid = wv; bus.wb_a3 = wa; bus.wb_wd = wd;
        #1;
        h1 = BYP && cnt[r1] == 1 && wv && wa == r1;
        h2 = BYP && cnt[r2] == 1 && wv && wa == r2;
        full = we && a3 != 0 && cnt[a3] == 3 && !(wv && wa == a3);
        st = iv && (!(cnt[r1] == 0 || h1) || !(cnt[r2] == 0 || h2) || full);
        check("stall", 32'(bus.stall), 32'(st));
        fire = iv && !st;
        eov = fire;
        if (fire) begin
            eop1 = r1 == 0 ? 32'h0 : h1 ? wd : d1;
            eop2 = r2 == 0 ? 32'h0 : h2 ? wd : d2;
        end
        inc = fire && we && a3 != 0;
        dec = wv && wa != 0;
        if (dec && cnt[wa] == 0) err = 1;
        if (!(inc && dec && a3 == wa)) begin
            if (inc) cnt[a3]++;
            if (dec && cnt[wa] > 0) cnt[wa]--;
        end
        @(posedge clk); #1;
        check("op_valid", 32'(bus.op_valid), 32'(eov));
        check("op1", bus.op1, eop1);
        check("op2", bus.op2, eop2);
        check("sb_err", 32'(bus.sb_err), 32'(err));
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] pend [$];
        logic [4:0] wa;
        idle();
        model_reset();
        clr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1;
        #1;
        check("rst_op_valid", 32'(bus.op_valid), 0);
        check("rst_sb_err", 32'(bus.sb_err), 0);
        check("rst_op1", bus.op1, 0);
        check("rst_stall", 32'(bus.stall), 0);
        @(negedge clk);
        // writer of $5, then readers with no writeback stall
        step(1, 1, 5, 1, 2, 32'h11, 32'h22, 0, 0, 0);
        repeat (3) step(1, 0, 0, 5, 0, 32'h55, 0, 0, 0, 0);
        // writeback to $5 while its reader issues
        step(1, 0, 0, 5, 0, 32'h5555, 0, 1, 5, 32'hDEADBEEF);
        if (!BYP) step(1, 0, 0, 5, 0, 32'h5555, 0, 0, 0, 0);
        // fill $7 to saturation; the fourth issue only fires with a same-cycle writeback
        repeat (3) step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 3, 0, 32'h33, 0, 1, 7, 32'h77);
        step(1, 0, 0, 7, 7, 0, 0, 1, 7, 32'h7);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h7);
        step(1, 0, 0, 7, 0, 32'h7777, 0, 0, 0, 0);
        // writebacks to $0 are ignored, to an idle $9 they flag underflow
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // asynchronous reset in the middle of a stall
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        bus.issue_valid = 1; bus.issue_we = 0; bus.rs_a1 = 5;
        #1;
        check("pre_rst_stall", 32'(bus.stall), 1);
        clr = 0;
        #1;
        check("async_stall", 32'(bus.stall), 0);
        check("async_op_valid", 32'(bus.op_valid), 0);
        check("async_sb_err", 32'(bus.sb_err), 0);
        check("async_op1", bus.op1, 0);
        bus.issue_valid = 0; bus.wb_valid = 1; bus.wb_a3 = 5;
        @(posedge clk);
        @(negedge clk);
        clr = 1;
        model_reset();
        step(1, 0, 0, 5, 9, 32'hA5, 32'h5A, 0, 0, 0);
        // random traffic over a small register window to force conflicts
        for (int c = 0; c < 3000; c++) begin
            pend.delete();
            for (int r = 1; r < 8; r++) if (cnt[r] != 0) pend.push_back(5'(r));
            wa = (pend.size() != 0 && $urandom_range(0, 9) != 0)
                 ? pend[$urandom_range(0, pend.size() - 1)] : 5'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                 $urandom_range(0, 2) == 0, wa, $urandom);
            if (c == 1500) begin
                clr = 0;
                #1;
                check("mid_rst_op_valid", 32'(bus.op_valid), 0);
                @(negedge clk);
                clr = 1;
                model_reset();
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
